// File: rtl/dlx_hazard_ctrl_if.sv
// Decode/execute-side signal bundle for the DLX hazard controller.
// The master drives the decoded ID fields and the EX branch outcome; the slave returns the controls.
interface dlx_hazard_ctrl_if #(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned REG_W    = 5,
    parameter int unsigned CNT_W    = 16
);
    logic                id_valid;
    logic [REG_W-1:0]    id_rs1;
    logic [REG_W-1:0]    id_rs2;
    logic                id_uses_rs1;
    logic                id_uses_rs2;
    logic                id_is_load;
    logic [REG_W-1:0]    id_rd;
    logic                ex_branch_taken;
    logic                stall;
    logic                kill;
    logic                issue;
    logic [NUM_REGS-1:0] busy_mask;
    logic [CNT_W-1:0]    stall_count;

    modport master (
        output id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_is_load, id_rd,
               ex_branch_taken,
        input  stall, kill, issue, busy_mask, stall_count
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_is_load, id_rd,
               ex_branch_taken,
        output stall, kill, issue, busy_mask, stall_count
    );
endinterface

// File: rtl/dlx_hazard_ctrl.sv
// DLX hazard controller: per-register load scoreboard drives stall, a branch-squash
// counter drives kill, and a saturating counter tracks stall cycles.
module dlx_hazard_ctrl #(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned REG_W    = 5,
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned BR_KILL  = 1,
    parameter int unsigned CNT_W    = 16
) (
    input logic             clk,
    input logic             reset,
    dlx_hazard_ctrl_if.slave bus
);
    localparam int unsigned SB_W  = $clog2(LOAD_LAT + 1);
    localparam int unsigned IDX_N = 2 ** REG_W;

    logic [SB_W-1:0]     cnt_q [NUM_REGS];
    logic [SB_W-1:0]     cnt_d [NUM_REGS];
    logic [1:0]          kcnt_q, kcnt_d;
    logic [CNT_W-1:0]    stall_count_q, stall_count_d;

    logic [NUM_REGS-1:0] busy;
    logic [IDX_N-1:0]    busy_ext;
    logic                hazard, stall, kill, issue, set_load;

    always_comb begin
        busy = '0;
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            busy[i] = (i != 0) && (cnt_q[i] != '0);
        end
    end

    // Pad to the full index range so out-of-range source indices read as not busy.
    assign busy_ext = IDX_N'(busy);

    assign hazard   = bus.id_valid & ((bus.id_uses_rs1 & busy_ext[bus.id_rs1]) |
                                      (bus.id_uses_rs2 & busy_ext[bus.id_rs2]));
    assign kill     = bus.ex_branch_taken | (kcnt_q != 2'd0);
    assign stall    = hazard & ~kill;
    assign issue    = bus.id_valid & ~stall & ~kill;
    assign set_load = issue & bus.id_is_load;

    always_comb begin
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            cnt_d[i] = cnt_q[i];
            // A fresh load wins over the decrement, so a WAW reload restarts the window.
            if (set_load && (i != 0) && (bus.id_rd == REG_W'(i))) begin
                cnt_d[i] = SB_W'(LOAD_LAT);
            end else if (cnt_q[i] != '0) begin
                cnt_d[i] = cnt_q[i] - SB_W'(1);
            end
        end
    end

    always_comb begin
        kcnt_d = kcnt_q;
        if (bus.ex_branch_taken) begin
            kcnt_d = 2'(BR_KILL - 1);
        end else if (kcnt_q != 2'd0) begin
            kcnt_d = kcnt_q - 2'd1;
        end
    end

    always_comb begin
        stall_count_d = stall_count_q;
        if (stall && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                cnt_q[i] <= '0;
            end
            kcnt_q        <= 2'd0;
            stall_count_q <= '0;
        end else begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            kcnt_q        <= kcnt_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign bus.stall       = stall;
    assign bus.kill        = kill;
    assign bus.issue       = issue;
    assign bus.busy_mask   = busy;
    assign bus.stall_count = stall_count_q;
endmodule

// File: tb/tb_dlx_hazard_ctrl.sv
// Scoreboard bench: two controller instances (LOAD_LAT=3/BR_KILL=2/CNT_W=4 and the defaults)
// driven by directed per-cycle vectors whose expected outputs are queued and checked at negedge.
module tb_dlx_hazard_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    dlx_hazard_ctrl_if #(.NUM_REGS(32), .REG_W(5), .CNT_W(4))  ifa ();
    dlx_hazard_ctrl_if #(.NUM_REGS(32), .REG_W(5), .CNT_W(16)) ifb ();

    dlx_hazard_ctrl #(
        .NUM_REGS(32), .REG_W(5), .LOAD_LAT(3), .BR_KILL(2), .CNT_W(4)
    ) dut_a (
        .clk(clk), .reset(reset), .bus(ifa)
    );

    dlx_hazard_ctrl #(
        .NUM_REGS(32), .REG_W(5), .LOAD_LAT(1), .BR_KILL(1), .CNT_W(16)
    ) dut_b (
        .clk(clk), .reset(reset), .bus(ifb)
    );

    typedef struct packed {
        logic        stall;
        logic        kill;
        logic        issue;
        logic [31:0] busy;
        logic [15:0] cnt;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    exp_t ea, eb;
    always @(negedge clk) begin
        if (qa.size() != 0) begin
            ea = qa.pop_front();
            check("A.stall", 32'(ifa.stall), 32'(ea.stall));
            check("A.kill", 32'(ifa.kill), 32'(ea.kill));
            check("A.issue", 32'(ifa.issue), 32'(ea.issue));
            check("A.busy_mask", ifa.busy_mask, ea.busy);
            check("A.stall_count", 32'(ifa.stall_count), 32'(ea.cnt));
        end
    end

    always @(negedge clk) begin
        if (qb.size() != 0) begin
            eb = qb.pop_front();
            check("B.stall", 32'(ifb.stall), 32'(eb.stall));
            check("B.kill", 32'(ifb.kill), 32'(eb.kill));
            check("B.issue", 32'(ifb.issue), 32'(eb.issue));
            check("B.busy_mask", ifb.busy_mask, eb.busy);
            check("B.stall_count", 32'(ifb.stall_count), 32'(eb.cnt));
        end
    end

    // One cycle: drive ID/EX inputs of the selected DUT, queue the expected outputs, advance.
    task automatic row(input bit sel, input bit v, input logic [4:0] rs1, input bit u1,
                       input logic [4:0] rs2, input bit u2, input bit ld, input logic [4:0] rd,
                       input bit br, input bit es, input bit ek, input bit ei,
                       input logic [31:0] ebusy, input logic [15:0] ecnt);
        exp_t e;
        e.stall = es;
        e.kill  = ek;
        e.issue = ei;
        e.busy  = ebusy;
        e.cnt   = ecnt;
        if (!sel) begin
            ifa.id_valid = v;  ifa.id_rs1 = rs1;  ifa.id_uses_rs1 = u1;
            ifa.id_rs2 = rs2;  ifa.id_uses_rs2 = u2;
            ifa.id_is_load = ld;  ifa.id_rd = rd;  ifa.ex_branch_taken = br;
            qa.push_back(e);
        end else begin
            ifb.id_valid = v;  ifb.id_rs1 = rs1;  ifb.id_uses_rs1 = u1;
            ifb.id_rs2 = rs2;  ifb.id_uses_rs2 = u2;
            ifb.id_is_load = ld;  ifb.id_rd = rd;  ifb.ex_branch_taken = br;
            qb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit sel, input logic [31:0] ebusy, input logic [15:0] ecnt);
        row(sel, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ebusy, ecnt);
    endtask

    int s;

    initial begin
        ifa.id_valid = 0;  ifa.id_rs1 = 0;  ifa.id_rs2 = 0;  ifa.id_uses_rs1 = 0;
        ifa.id_uses_rs2 = 0;  ifa.id_is_load = 0;  ifa.id_rd = 0;  ifa.ex_branch_taken = 0;
        ifb.id_valid = 0;  ifb.id_rs1 = 0;  ifb.id_rs2 = 0;  ifb.id_uses_rs1 = 0;
        ifb.id_uses_rs2 = 0;  ifb.id_is_load = 0;  ifb.id_rd = 0;  ifb.ex_branch_taken = 0;
        @(posedge clk);
        #1;

        // Load stream under reset: nothing may be recorded.
        row(0, 1, 1, 1, 0, 0, 1, 3, 0,  0, 0, 1, 32'h0, 0);
        row(0, 1, 1, 1, 0, 0, 1, 5, 0,  0, 0, 1, 32'h0, 0);
        row(1, 1, 1, 1, 0, 0, 1, 3, 0,  0, 0, 1, 32'h0, 0);
        ifb.id_valid = 0;
        ifb.id_is_load = 0;
        reset = 0;

        // DUT A: LOAD_LAT=3, BR_KILL=2, CNT_W=4
        row(0, 1, 1, 1, 2, 1, 0, 4, 0,  0, 0, 1, 32'h0, 0);
        row(0, 1, 1, 1, 0, 0, 1, 3, 0,  0, 0, 1, 32'h0, 0);       // lw r3
        for (int j = 0; j < 3; j++) begin
            row(0, 1, 3, 1, 5, 1, 0, 4, 0,  1, 0, 0, 32'h8, 16'(j)); // add r4,r3,r5 stalls
        end
        row(0, 1, 3, 1, 5, 1, 0, 4, 0,  0, 0, 1, 32'h0, 3);
        row(0, 1, 1, 1, 0, 0, 1, 0, 0,  0, 0, 1, 32'h0, 3);       // lw r0
        row(0, 1, 0, 1, 0, 1, 0, 4, 0,  0, 0, 1, 32'h0, 3);       // use r0
        row(0, 1, 1, 1, 0, 0, 1, 3, 0,  0, 0, 1, 32'h0, 3);       // lw r3
        row(0, 1, 6, 1, 7, 1, 0, 4, 0,  0, 0, 1, 32'h8, 3);       // independent add
        idle(0, 32'h8, 3);
        idle(0, 32'h8, 3);
        idle(0, 32'h0, 3);
        // Branch squash: load killed in ID leaves the scoreboard clear.
        row(0, 1, 1, 1, 0, 0, 1, 5, 1,  0, 1, 0, 32'h0, 3);
        row(0, 1, 1, 1, 0, 0, 1, 5, 0,  0, 1, 0, 32'h0, 3);
        row(0, 1, 1, 1, 2, 1, 0, 4, 1,  0, 1, 0, 32'h0, 3);
        row(0, 1, 1, 1, 2, 1, 0, 4, 1,  0, 1, 0, 32'h0, 3);       // second branch restarts
        row(0, 1, 1, 1, 2, 1, 0, 4, 0,  0, 1, 0, 32'h0, 3);
        row(0, 1, 1, 1, 2, 1, 0, 4, 0,  0, 0, 1, 32'h0, 3);
        // Hazard coinciding with a taken branch: kill overrides stall.
        row(0, 1, 1, 1, 0, 0, 1, 3, 0,  0, 0, 1, 32'h0, 3);
        row(0, 1, 3, 1, 0, 0, 0, 4, 1,  0, 1, 0, 32'h8, 3);
        row(0, 1, 3, 1, 0, 0, 0, 4, 0,  0, 1, 0, 32'h8, 3);
        row(0, 1, 3, 1, 0, 0, 0, 4, 0,  1, 0, 0, 32'h8, 3);
        row(0, 1, 3, 1, 0, 0, 0, 4, 0,  0, 0, 1, 32'h0, 4);
        // WAW reload of r5 while its counter is decrementing.
        row(0, 1, 1, 1, 0, 0, 1, 5, 0,  0, 0, 1, 32'h0, 4);
        idle(0, 32'h20, 4);
        row(0, 1, 1, 1, 0, 0, 1, 5, 0,  0, 0, 1, 32'h20, 4);
        idle(0, 32'h20, 4);
        idle(0, 32'h20, 4);
        idle(0, 32'h20, 4);
        idle(0, 32'h0, 4);
        // Repeated load-use pairs drive the 4-bit stall counter into saturation.
        s = 4;
        for (int k = 0; k < 5; k++) begin
            row(0, 1, 1, 1, 0, 0, 1, 3, 0,  0, 0, 1, 32'h0, 16'(s));
            for (int j = 0; j < 3; j++) begin
                row(0, 1, 3, 1, 0, 0, 0, 4, 0,  1, 0, 0, 32'h8, 16'((s + j > 15) ? 15 : s + j));
            end
            s = (s + 3 > 15) ? 15 : s + 3;
        end
        idle(0, 32'h0, 15);
        // Asynchronous reset mid-operation clears state before the next edge.
        row(0, 1, 1, 1, 0, 0, 1, 3, 0,  0, 0, 1, 32'h0, 15);
        reset = 1;
        idle(0, 32'h0, 0);
        reset = 0;

        // DUT B: LOAD_LAT=1, BR_KILL=1, CNT_W=16
        row(1, 1, 1, 1, 0, 0, 1, 3, 0,  0, 0, 1, 32'h0, 0);       // lw r3
        row(1, 1, 3, 1, 5, 1, 0, 4, 0,  1, 0, 0, 32'h8, 0);       // one-cycle stall
        row(1, 1, 3, 1, 5, 1, 0, 4, 0,  0, 0, 1, 32'h0, 1);
        row(1, 1, 1, 1, 0, 0, 1, 3, 0,  0, 0, 1, 32'h0, 1);
        row(1, 1, 6, 1, 7, 1, 0, 4, 0,  0, 0, 1, 32'h8, 1);
        idle(1, 32'h0, 1);
        row(1, 1, 1, 1, 2, 1, 0, 4, 1,  0, 1, 0, 32'h0, 1);
        row(1, 1, 1, 1, 2, 1, 0, 4, 0,  0, 0, 1, 32'h0, 1);
        row(1, 1, 1, 1, 0, 0, 1, 7, 1,  0, 1, 0, 32'h0, 1);       // killed lw r7
        row(1, 1, 7, 1, 0, 0, 0, 1, 0,  0, 0, 1, 32'h0, 1);

        @(posedge clk);
        #1;
        check("A.queue_drained", 32'(qa.size()), 32'd0);
        check("B.queue_drained", 32'(qb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/dlx_hazard_ctrl.md
# dlx_hazard_ctrl

Parametrised pipeline hazard controller for the DLX datapath. It replaces the fixed one-bubble load-use stall and single-slot kill with two mechanisms. A per-register load scoreboard with configurable load latency drives the stall. A branch-squash counter with configurable kill depth drives the kill. It sits beside the decode stage: it takes decoded register fields from ID and the resolved branch outcome from EX, and returns stall/kill/issue to the IF/ID and ID/EX pipeline registers.

## Interface
- NUM_REGS, 32, number of architectural integer registers; r0 is hardwired zero.
- REG_W, 5, register index width; NUM_REGS <= 2**REG_W.
- LOAD_LAT, 1, cycles after a load issues before a dependent instruction may issue; range 1..7.
- BR_KILL, 1, number of consecutive ID slots squashed per taken branch/jump; range 1..3.
- CNT_W, 16, width of the stall performance counter.

- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high; clears all state.
- id_valid  in  1  ID holds a valid instruction.
- id_rs1, id_rs2  in  REG_W  source register indices.
- id_uses_rs1, id_uses_rs2  in  1  the instruction reads that source.
- id_is_load  in  1  instruction is lw/lh/lb/lbu/lhu.
- id_rd  in  REG_W  destination index.
- ex_branch_taken  in  1  EX resolved a taken branch or jump this cycle.
- stall  out  1  hold PC and IF/ID; inject a bubble into ID/EX.
- kill  out  1  the instruction in ID is squashed (no RegWr/MemWr/MemToReg downstream).
- issue  out  1  the instruction in ID advances this cycle.
- busy_mask  out  NUM_REGS  bit i set when counter i is nonzero.
- stall_count  out  CNT_W  saturating count of stall cycles.

## Operation
- Scoreboard: one counter per register, width clog2(LOAD_LAT+1), reset 0. busy[i] = (cnt[i] != 0); busy[0] is forced 0.
- hazard = id_valid & ((id_uses_rs1 & busy[id_rs1]) | (id_uses_rs2 & busy[id_rs2])).
- Kill counter kcnt, width 2, reset 0. kill = ex_branch_taken | (kcnt != 0).
- stall = hazard & ~kill. Kill overrides stall, because a squashed instruction need not wait.
- issue = id_valid & ~stall & ~kill.
- Per clock edge, for each register i:
  - If issue & id_is_load & id_rd == i & i != 0, then cnt[i] <= LOAD_LAT. This set wins over the decrement, which also covers a WAW reload of an already busy register.
  - Otherwise, if cnt[i] != 0, cnt[i] decrements by 1.
- Kill counter, per clock edge:
  - If ex_branch_taken, kcnt <= BR_KILL-1. A new branch while kill is active restarts the window.
  - Otherwise, if kcnt != 0, kcnt decrements by 1.
- Killed or stalled loads never set the scoreboard. A load to r0 never sets it.
- stall_count increments on each cycle with stall=1 and saturates at all-ones with no wrap.
- Asynchronous reset mid-operation clears every counter immediately. Outputs then follow the combinational equations with all state at zero.

## Timing
- stall, kill and issue are combinational from the inputs and current state, with no registered delay.
- busy_mask is a combinational decode of the registered counters.
- stall_count is registered.
- Reset values: busy_mask=0 and stall_count=0. stall, kill and issue are 0 unless inputs force them (kill=ex_branch_taken; issue=id_valid).
- Load-use penalty: a consumer immediately after a load stalls exactly LOAD_LAT cycles.
- Taken branch in EX at cycle t: kill is high on cycles t .. t+BR_KILL-1.
- A consumer at distance d > LOAD_LAT after the load never stalls.

## Test plan
- Reset: hold reset with id_valid=1 and a random load stream → busy_mask=0, stall=0, stall_count=0. Deassert reset → first instruction has issue=1.
- LOAD_LAT=1: lw r3 issues at cycle 10, then add r4,r3,r5 in ID at cycle 11 → stall=1 at 11 only, issue=1 at 12, stall_count=1. Same case with LOAD_LAT=3 → stall at cycles 11-13, issue at 14, stall_count=3.
- Non-dependent source and r0: lw r0 followed by use of r0 → no stall. lw r3 followed by add r4,r6,r7 → no stall, busy_mask=0x8 for one cycle.
- Branch squash with BR_KILL=2: ex_branch_taken at cycle 20 → kill=1 at cycles 20-21, issue=0 there, and a load in ID at cycle 20 leaves busy_mask unchanged. A second taken branch at cycle 21 extends kill through cycle 22.
- Simultaneous events: at the same cycle, a hazard stall on r3 and ex_branch_taken → stall=0, kill=1. At the same cycle, a load to r5 issues while cnt[5] is decrementing (WAW) → cnt[5] reloads to LOAD_LAT.
- Saturation with CNT_W=4: force 20 consecutive stall cycles → stall_count holds at 15.
